// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read channel (AR/R) between the icache and dcache miss ports.
// One transaction in flight at a time; ties are broken round-robin.
module cache_rd_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_rd_req,
    input  logic [2:0]  inst_rd_type,
    input  logic [31:0] inst_rd_addr,
    output logic        inst_rd_rdy,
    output logic        inst_ret_valid,
    output logic        inst_ret_last,
    output logic [31:0] inst_rdata,

    input  logic        data_rd_req,
    input  logic [2:0]  data_rd_type,
    input  logic [31:0] data_rd_addr,
    output logic        data_rd_rdy,
    output logic        data_ret_valid,
    output logic        data_ret_last,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic [31:0] araddr_q;
    logic [3:0]  arid_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q;
    logic        ownerData_q;
    logic        lastGrantData_q;

    logic        grantInst, grantData, accept;
    logic [2:0]  selType;
    logic [31:0] selAddr;
    logic        selLine;
    logic        unusedBits;

    // Routing relies only on the registered owner, so rid/rresp carry no meaning here.
    assign unusedBits = ^{rid, rresp};

    // On a tie the port that did not win last time gets the channel.
    assign grantData = (state_q == IDLE) && data_rd_req && (!inst_rd_req || !lastGrantData_q);
    assign grantInst = (state_q == IDLE) && inst_rd_req && !grantData;
    assign accept    = grantInst || grantData;

    assign selType = grantData ? data_rd_type : inst_rd_type;
    assign selAddr = grantData ? data_rd_addr : inst_rd_addr;
    assign selLine = (selType == 3'b100);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)          state_d = AR;
            AR:   if (arready)         state_d = R;
            R:    if (rvalid && rlast) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            araddr_q        <= 32'd0;
            arid_q          <= 4'd0;
            arlen_q         <= 8'd0;
            arsize_q        <= 3'd0;
            ownerData_q     <= 1'b0;
            lastGrantData_q <= 1'b0;
        end else if (accept) begin
            araddr_q        <= selAddr;
            arid_q          <= grantData ? DATA_ID : INST_ID;
            arlen_q         <= selLine ? 8'd3 : 8'd0;
            arsize_q        <= selLine ? 3'd2 : {1'b0, selType[1:0]};
            ownerData_q     <= grantData;
            lastGrantData_q <= grantData;
        end
    end

    // Every output is forced low while reset is held, including the fixed burst type.
    always_comb begin
        inst_rd_rdy    = 1'b0;
        inst_ret_valid = 1'b0;
        inst_ret_last  = 1'b0;
        inst_rdata     = 32'd0;
        data_rd_rdy    = 1'b0;
        data_ret_valid = 1'b0;
        data_ret_last  = 1'b0;
        data_rdata     = 32'd0;
        arid           = 4'd0;
        araddr         = 32'd0;
        arlen          = 8'd0;
        arsize         = 3'd0;
        arburst        = 2'b00;
        arvalid        = 1'b0;
        rready         = 1'b0;
        if (resetn) begin
            arid    = arid_q;
            araddr  = araddr_q;
            arlen   = arlen_q;
            arsize  = arsize_q;
            arburst = 2'b01;
            case (state_q)
                IDLE: begin
                    inst_rd_rdy = grantInst;
                    data_rd_rdy = grantData;
                end
                AR: begin
                    arvalid = 1'b1;
                end
                R: begin
                    rready = 1'b1;
                    if (ownerData_q) begin
                        data_ret_valid = rvalid;
                        data_ret_last  = rvalid && rlast;
                        data_rdata     = rdata;
                    end else begin
                        inst_ret_valid = rvalid;
                        inst_ret_last  = rvalid && rlast;
                        inst_rdata     = rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

endmodule
